// File: rtl/conv_row_feeder.sv
// conv_row_feeder: streams a 3-row band of an image from memory into rotating row
// buffers and serves it column by column, sliding the band by stride 1 or 2.
module conv_row_feeder #(
    parameter int BIT_DEPTH = 8,
    parameter int IMG_W     = 28,
    parameter int IMG_H     = 28,
    parameter int ADDR_W    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic [1:0]           stride,
    input  logic [ADDR_W-1:0]    base_addr,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [BIT_DEPTH-1:0] mem_rd_data,
    output logic                 conv_start,
    input  logic                 shift_buffer,
    input  logic                 conv_done,
    output logic [BIT_DEPTH-1:0] in_l1,
    output logic [BIT_DEPTH-1:0] in_l2,
    output logic [BIT_DEPTH-1:0] in_l3,
    output logic [4:0]           band_row,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int CW = $clog2(IMG_W + 1);
    localparam int IW = $clog2(IMG_W);
    localparam int LW = $clog2(3 * IMG_W);

    typedef enum logic [2:0] {IDLE, FILL, START, STREAM, DONE} state_t;

    state_t                r_state;
    logic                  r_s2;
    logic [ADDR_W-1:0]     r_base;
    logic [4:0]            r_row;
    logic [1:0]            r_top;
    logic [LW-1:0]         r_left;
    logic                  r_rd_en;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_vld;
    logic [1:0]            r_wk;
    logic [IW-1:0]         r_wc;
    logic [CW-1:0]         r_col;
    logic                  r_conv_start;
    logic                  r_frame_done;
    logic [BIT_DEPTH-1:0]  r_buf [3][IMG_W];

    logic [1:0]            w_step;
    logic [5:0]            w_next_row;
    logic                  w_more;
    logic [ADDR_W-1:0]     w_refill_addr;
    logic [1:0]            w_next_top;
    logic [1:0]            w_p1;
    logic [1:0]            w_p2;
    logic [1:0]            w_wp;
    logic                  w_we;
    logic                  w_wc_last;
    logic                  w_on;
    logic [IW-1:0]         w_ci;

    function automatic logic [1:0] mod3(input logic [2:0] v);
        return v >= 3'd3 ? 2'(v - 3'd3) : v[1:0];
    endfunction

    assign w_step        = r_s2 ? 2'd2 : 2'd1;
    assign w_next_row    = {1'b0, r_row} + {4'b0, w_step};
    assign w_more        = int'(w_next_row) + 2 <= IMG_H - 1;
    // Rows retained across a slide are never re-read, so the refill always starts at old row + 3.
    assign w_refill_addr = r_base + ADDR_W'((int'(r_row) + 3) * IMG_W);
    assign w_next_top    = mod3({1'b0, r_top} + {1'b0, w_step});
    assign w_p1          = mod3({1'b0, r_top} + 3'd1);
    assign w_p2          = mod3({1'b0, r_top} + 3'd2);
    assign w_wp          = mod3({1'b0, r_top} + {1'b0, r_wk});
    assign w_we          = r_state == FILL && r_vld && !rst;
    assign w_wc_last     = r_wc == IW'(IMG_W - 1);
    assign w_on          = r_state == STREAM && r_col < CW'(IMG_W);
    assign w_ci          = r_col[IW-1:0];

    assign in_l1      = w_on ? r_buf[r_top][w_ci] : '0;
    assign in_l2      = w_on ? r_buf[w_p1][w_ci] : '0;
    assign in_l3      = w_on ? r_buf[w_p2][w_ci] : '0;
    assign mem_rd_en  = r_rd_en;
    assign mem_addr   = r_addr;
    assign conv_start = r_conv_start;
    assign frame_done = r_frame_done;
    assign band_row   = r_row;
    assign busy       = r_state != IDLE;

    always_ff @(posedge clk) begin
        if (w_we) r_buf[w_wp][r_wc] <= mem_rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_s2         <= 1'b0;
            r_base       <= '0;
            r_row        <= '0;
            r_top        <= '0;
            r_left       <= '0;
            r_rd_en      <= 1'b0;
            r_addr       <= '0;
            r_vld        <= 1'b0;
            r_wk         <= '0;
            r_wc         <= '0;
            r_col        <= '0;
            r_conv_start <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_conv_start <= 1'b0;
            r_frame_done <= 1'b0;
            r_vld        <= r_rd_en;
            case (r_state)
                IDLE: if (frame_start) begin
                    r_state <= FILL;
                    r_s2    <= stride == 2'd2;
                    r_base  <= base_addr;
                    r_row   <= '0;
                    r_top   <= '0;
                    r_rd_en <= 1'b1;
                    r_addr  <= base_addr;
                    r_left  <= LW'(3 * IMG_W - 1);
                    r_wk    <= '0;
                    r_wc    <= '0;
                end
                FILL: begin
                    if (r_rd_en) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_left  <= r_left - LW'(1);
                        r_rd_en <= r_left != '0;
                    end
                    if (r_vld) begin
                        r_wc <= w_wc_last ? '0 : r_wc + IW'(1);
                        r_wk <= w_wc_last ? r_wk + 2'd1 : r_wk;
                    end
                    if (r_vld && !r_rd_en) begin
                        r_state      <= START;
                        r_conv_start <= 1'b1;
                    end
                end
                START: begin
                    r_col   <= '0;
                    r_state <= STREAM;
                end
                STREAM: if (conv_done) begin
                    if (w_more) begin
                        r_state <= FILL;
                        r_row   <= w_next_row[4:0];
                        r_top   <= w_next_top;
                        r_rd_en <= 1'b1;
                        r_addr  <= w_refill_addr;
                        r_left  <= r_s2 ? LW'(2 * IMG_W - 1) : LW'(IMG_W - 1);
                        r_wk    <= r_s2 ? 2'd1 : 2'd2;
                        r_wc    <= '0;
                    end else begin
                        r_state      <= DONE;
                        r_frame_done <= 1'b1;
                    end
                end else if (shift_buffer && r_col != CW'(IMG_W)) begin
                    r_col <= r_col + CW'(1);
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
